// File: rtl/seg_scan.sv
// Multiplexed 4-digit seven-segment scanner with per-frame shadowing of dat/dp.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan #(
  parameter int DWELL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce1ms,
  input  logic        en,
  input  logic [15:0] dat,
  input  logic [3:0]  dp,
  output logic [6:0]  seg,
  output logic        seg_p,
  output logic [3:0]  an,
  output logic        frame
);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  state_t      state_q, state_d;
  logic [3:0]  dwell_q, dwell_d;
  logic [1:0]  dig_q, dig_d;
  logic [19:0] shadow_q, shadow_d;
  logic        frame_q, frame_d;
  logic [6:0]  seg_q, seg_d;
  logic        segp_q, segp_d;
  logic [3:0]  an_q, an_d;

  logic        strobe;
  logic [15:0] shDat;
  logic [3:0]  nib;
  logic        blankLead;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign strobe = ce1ms & en;
  assign shDat  = shadow_q[19:4];
  assign nib    = shDat[{dig_q, 2'b00} +: 4];

  // The first strobe after reset only captures a frame; later strobes count dwell and advance.
  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    dig_d    = dig_q;
    shadow_d = shadow_q;
    frame_d  = 1'b0;
    if (strobe) begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_SCAN;
          shadow_d = {dat, dp};
          dig_d    = 2'd0;
          dwell_d  = 4'd0;
        end
        ST_SCAN: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = 4'd0;
            dig_d   = dig_q + 2'd1;
            if (dig_q == 2'd3) begin
              shadow_d = {dat, dp};
              frame_d  = 1'b1;
            end
          end else begin
            dwell_d = dwell_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef SEG_SCAN_LZB_EN
  always_comb begin
    case (dig_q)
      2'd1:    blankLead = (shDat[15:4] == 12'h000);
      2'd2:    blankLead = (shDat[15:8] == 8'h00);
      2'd3:    blankLead = (shDat[15:12] == 4'h0);
      default: blankLead = 1'b0;
    endcase
  end
`else
  assign blankLead = 1'b0;
`endif

  // Outputs are built from the registered digit, so they trail a digit advance by one clock.
  always_comb begin
    seg_d  = 7'h7F;
    segp_d = 1'b1;
    an_d   = 4'hF;
    if ((state_q == ST_SCAN) && en) begin
      an_d   = ~(4'b0001 << dig_q);
      seg_d  = blankLead ? 7'h7F : hex7(nib);
      segp_d = ~shadow_q[dig_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dwell_q  <= 4'd0;
      dig_q    <= 2'd0;
      shadow_q <= 20'd0;
      frame_q  <= 1'b0;
      seg_q    <= 7'h7F;
      segp_q   <= 1'b1;
      an_q     <= 4'hF;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      dig_q    <= dig_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      seg_q    <= seg_d;
      segp_q   <= segp_d;
      an_q     <= an_d;
    end
  end

  assign seg   = seg_q;
  assign seg_p = segp_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: two instances (DWELL=1 and DWELL=3) checked against
// a strobe-count reference model; honours SEG_SCAN_LZB_EN for expected blanking.
module tb_seg_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ce1ms;
  logic        en;
  logic [15:0] dat;
  logic [3:0]  dp;

  logic [6:0] seg1, seg3;
  logic       segp1, segp3;
  logic [3:0] an1, an3;
  logic       frame1, frame3;

  seg_scan #(.DWELL(1)) u1 (
    .clk(clk), .rst(rst), .ce1ms(ce1ms), .en(en), .dat(dat), .dp(dp),
    .seg(seg1), .seg_p(segp1), .an(an1), .frame(frame1)
  );

  seg_scan #(.DWELL(3)) u3 (
    .clk(clk), .rst(rst), .ce1ms(ce1ms), .en(en), .dat(dat), .dp(dp),
    .seg(seg3), .seg_p(segp3), .an(an3), .frame(frame3)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       segp;
    logic [3:0] an;
    logic       frame;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int compared = 0;
  int mismatched = 0;

  logic [6:0] hexTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state: the digit shown follows from how many strobes have been counted since the first one.
  bit          mStarted [2];
  int          mCount   [2];
  logic [19:0] mShadow  [2];

  function automatic exp_t modelStep(input int idx, input int dw);
    exp_t        e;
    int          d;
    logic [15:0] sd;
    e.seg   = 7'h7F;
    e.segp  = 1'b1;
    e.an    = 4'hF;
    e.frame = 1'b0;
    if (rst) begin
      mStarted[idx] = 1'b0;
      mCount[idx]   = 0;
      mShadow[idx]  = 20'd0;
      return e;
    end
    if (mStarted[idx] && en) begin
      d      = (mCount[idx] / dw) % 4;
      sd     = mShadow[idx][19:4];
      e.an[d] = 1'b0;
      e.seg  = hexTab[sd[d*4 +: 4]];
`ifdef SEG_SCAN_LZB_EN
      if (d > 0 && (sd >> (4 * d)) == 16'h0000) e.seg = 7'h7F;
`endif
      e.segp = ~mShadow[idx][d];
    end
    if (ce1ms && en) begin
      if (!mStarted[idx]) begin
        mStarted[idx] = 1'b1;
        mCount[idx]   = 0;
        mShadow[idx]  = {dat, dp};
      end else begin
        mCount[idx] = mCount[idx] + 1;
        if (mCount[idx] % (4 * dw) == 0) begin
          mShadow[idx] = {dat, dp};
          e.frame = 1'b1;
        end
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    q1.push_back(modelStep(0, 1));
    q3.push_back(modelStep(1, 3));
  end

  task automatic checkOutput(input string name, input exp_t e, input exp_t a);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("[TB] FAIL %s t=%0t actual seg=%h segp=%b an=%h frame=%b required seg=%h segp=%b an=%h frame=%b",
               name, $time, a.seg, a.segp, a.an, a.frame, e.seg, e.segp, e.an, e.frame);
    end
    compared++;
    if ($countones(~a.an) > 1) begin
      mismatched++;
      $display("[TB] FAIL %s_onehot t=%0t actual an=%h required at most one low bit", name, $time, a.an);
    end
  endtask

  // Monitor: compare away from the active edge against the oldest expected frame.
  always @(negedge clk) begin
    if (q1.size() > 0) checkOutput("dwell1", q1.pop_front(), {seg1, segp1, an1, frame1});
    if (q3.size() > 0) checkOutput("dwell3", q3.pop_front(), {seg3, segp3, an3, frame3});
  end

  task automatic applyStimulus(input logic r, input logic c, input logic e,
                               input logic [15:0] d, input logic [3:0] p);
    @(negedge clk);
    rst   = r;
    ce1ms = c;
    en    = e;
    dat   = d;
    dp    = p;
  endtask

  task automatic strobes(input int n, input int gap, input logic [15:0] d, input logic [3:0] p);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, d, p);
      for (int j = 0; j < gap; j++) applyStimulus(1'b0, 1'b0, 1'b1, d, p);
    end
  endtask

  function automatic logic [15:0] randDat();
    logic [15:0] v;
    for (int k = 0; k < 4; k++) v[k*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    return v;
  endfunction

  initial begin
    logic [15:0] rd;
    logic [3:0]  rp;
    rst = 1'b1; ce1ms = 1'b0; en = 1'b0; dat = 16'h0; dp = 4'h0;
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);

    $display("[TB] basic scan 1234");
    strobes(26, 9, 16'h1234, 4'h0);

    $display("[TB] mid-frame data change");
    strobes(5, 2, 16'h1234, 4'h0);
    strobes(16, 2, 16'hABCD, 4'h5);

    $display("[TB] held ce1ms");
    strobes(6, 0, 16'hABCD, 4'h5);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 16'hABCD, 4'h5);

    $display("[TB] enable dropped");
    strobes(3, 3, 16'h5678, 4'h2);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, i[0], 1'b0, 16'h9999, 4'hF);
    strobes(8, 1, 16'h5678, 4'h2);

    $display("[TB] reset coincident with strobe");
    strobes(3, 1, 16'h4321, 4'h8);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h4321, 4'h8);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h4321, 4'h8);
    strobes(6, 1, 16'h0F0F, 4'h1);

    $display("[TB] leading zeros 0050");
    strobes(30, 1, 16'h0050, 4'b0100);
    strobes(12, 1, 16'h0000, 4'b0001);

    $display("[TB] randomized");
    rd = randDat();
    rp = 4'($urandom);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        rd = randDat();
        rp = 4'($urandom);
      end
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 9) != 0, rd, rp);
    end

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, rd, rp);
    compared++;
    if (q1.size() > 1 || q3.size() > 1) begin
      mismatched++;
      $display("[TB] FAIL drain actual q1=%0d q3=%0d required at most 1 pending", q1.size(), q3.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
